// File: rtl/tv80_pkg.sv
// tv80_pkg: shared state encoding, pair indices and default bank mask
package tv80_pkg;
    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
    localparam logic [2:0] REG_BC = 3'd0;
    localparam logic [2:0] REG_DE = 3'd1;
    localparam logic [2:0] REG_HL = 3'd2;
    localparam logic [2:0] REG_IX = 3'd3;
    localparam logic [2:0] REG_IY = 3'd7;
    localparam logic [7:0] XMASK_DEF = 8'b0000_0111;
endpackage

// File: rtl/tv80_regfile_bank_if.sv
// tv80_regfile_bank_if: register file command/read bus with master and slave views
interface tv80_regfile_bank_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          CEN;
    logic [AW-1:0] AddrA, AddrB, AddrC;
    logic [DW-1:0] DIH, DIL;
    logic          WEH, WEL, EXX;
    logic [DW-1:0] DOAH, DOAL, DOBH, DOBL, DOCH, DOCL;
    logic          alt_sel, busy;
    modport master (
        output CEN, AddrA, AddrB, AddrC, DIH, DIL, WEH, WEL, EXX,
        input  DOAH, DOAL, DOBH, DOBL, DOCH, DOCL, alt_sel, busy
    );
    modport slave (
        input  CEN, AddrA, AddrB, AddrC, DIH, DIL, WEH, WEL, EXX,
        output DOAH, DOAL, DOBH, DOBL, DOCH, DOCL, alt_sel, busy
    );
endinterface

// File: rtl/tv80_regfile_half.sv
// tv80_regfile_half: one DW-wide half array, one write port, three asynchronous reads
module tv80_regfile_half #(
    parameter int DW = 8,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] raddr [3],
    output logic [DW-1:0] rdata [3]
);
    logic [DW-1:0] mem_q [2**IW];
    // storage write; clearing after reset is driven by the owner's sweep
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
    // zero-latency read ports
    always_comb begin
        for (int i = 0; i < 3; i++) rdata[i] = mem_q[raddr[i]];
    end
endmodule

// File: rtl/tv80_regfile_bank.sv
// tv80_regfile_bank: banked register-pair file with EXX exchange and post-reset clear sweep; TV80_REGFILE_BYPASS_EN enables same-cycle write forwarding
module tv80_regfile_bank
    import tv80_pkg::*;
#(
    parameter int              DW    = 8,
    parameter int              NREGS = 8,
    parameter int              AW    = 3,
    parameter logic [NREGS-1:0] XMASK = XMASK_DEF
) (
    input logic               clk,
    input logic               reset,
    tv80_regfile_bank_if.slave bus
);
    state_t        state_q, state_d;
    logic [AW:0]   idx_q, idx_d;
    logic          alt_q, alt_d;
    logic          busy, op_en, byp_h, byp_l, we_h, we_l;
    logic [AW:0]   wa;
    logic [AW:0]   ra [3];
    logic [AW-1:0] addr [3];
    logic [DW-1:0] wd_h, wd_l;
    logic [DW-1:0] rh [3], rl [3], oh [3], ol [3];

    assign busy  = state_q == ST_CLEAR;
    assign op_en = bus.CEN & ~busy;

`ifdef TV80_REGFILE_BYPASS_EN
    assign byp_h = op_en & bus.WEH;
    assign byp_l = op_en & bus.WEL;
`else
    assign byp_h = 1'b0;
    assign byp_l = 1'b0;
`endif

    // sweep advance and bank toggle; both only move on enabled cycles
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (bus.CEN && busy) begin
            idx_d   = idx_q + 1'b1;
            state_d = &idx_q ? ST_IDLE : ST_CLEAR;
        end
        alt_d = (op_en && bus.EXX) ? ~alt_q : alt_q;
    end

    // write port: sweep zeroes by raw index, normal writes use the pre-toggle bank
    always_comb begin
        wa      = busy ? idx_q : {alt_q & XMASK[bus.AddrA], bus.AddrA};
        we_h    = ~reset & bus.CEN & (busy | bus.WEH);
        we_l    = ~reset & bus.CEN & (busy | bus.WEL);
        wd_h    = busy ? '0 : bus.DIH;
        wd_l    = busy ? '0 : bus.DIL;
        addr[0] = bus.AddrA;
        addr[1] = bus.AddrB;
        addr[2] = bus.AddrC;
        for (int i = 0; i < 3; i++) ra[i] = {alt_q & XMASK[addr[i]], addr[i]};
    end

    // read outputs: blanked while sweeping, optionally forwarded from the write port
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            oh[i] = busy ? '0 : (byp_h && ra[i] == wa) ? bus.DIH : rh[i];
            ol[i] = busy ? '0 : (byp_l && ra[i] == wa) ? bus.DIL : rl[i];
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            alt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            alt_q   <= alt_d;
        end
    end

    tv80_regfile_half #(.DW(DW), .IW(AW + 1)) u_h (
        .clk(clk), .we(we_h), .waddr(wa), .wdata(wd_h), .raddr(ra), .rdata(rh)
    );
    tv80_regfile_half #(.DW(DW), .IW(AW + 1)) u_l (
        .clk(clk), .we(we_l), .waddr(wa), .wdata(wd_l), .raddr(ra), .rdata(rl)
    );

    assign bus.DOAH    = oh[0];
    assign bus.DOAL    = ol[0];
    assign bus.DOBH    = oh[1];
    assign bus.DOBL    = ol[1];
    assign bus.DOCH    = oh[2];
    assign bus.DOCL    = ol[2];
    assign bus.alt_sel = alt_q;
    assign bus.busy    = busy;
endmodule

// File: tb/tb_tv80_regfile_bank.sv
// tb_tv80_regfile_bank: directed table, sweep corner cases and random traffic against a bank/array model
module tb_tv80_regfile_bank;
    import tv80_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    tv80_regfile_bank_if #(.DW(8), .AW(3)) bus ();
    tv80_regfile_bank dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] mh [2][8];
    logic [7:0] ml [2][8];
    int left = 16;
    logic alt = 1'b0;
    logic [7:0] xm = XMASK_DEF;
    int n;

    typedef struct {
        logic [2:0]  a;
        logic [2:0]  b;
        logic [15:0] di;
        logic        weh;
        logic        wel;
        logic        exx;
        logic [15:0] exp_b;
        logic        exp_alt;
    } vec_t;
    vec_t tv [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd(input logic [2:0] a);
        logic b;
        logic [7:0] h, l;
        if (left > 0) return 16'h0000;
        b = alt & xm[a];
        h = mh[b][a];
        l = ml[b][a];
`ifdef TV80_REGFILE_BYPASS_EN
        if (bus.CEN && a == bus.AddrA) begin
            if (bus.WEH) h = bus.DIH;
            if (bus.WEL) l = bus.DIL;
        end
`endif
        return {h, l};
    endfunction

    task automatic step();
        logic b;
        if (reset) begin
            left = 16;
            alt = 1'b0;
        end else if (bus.CEN) begin
            if (left > 0) begin
                left--;
                if (left == 0)
                    for (int k = 0; k < 2; k++)
                        for (int j = 0; j < 8; j++) begin
                            mh[k][j] = 8'h00;
                            ml[k][j] = 8'h00;
                        end
            end else begin
                b = alt & xm[bus.AddrA];
                if (bus.WEH) mh[b][bus.AddrA] = bus.DIH;
                if (bus.WEL) ml[b][bus.AddrA] = bus.DIL;
                if (bus.EXX) alt = ~alt;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("busy", {31'd0, bus.busy}, {31'd0, left > 0});
        chk("alt_sel", {31'd0, bus.alt_sel}, {31'd0, alt});
        chk("port_a", {16'd0, bus.DOAH, bus.DOAL}, {16'd0, exp_rd(bus.AddrA)});
        chk("port_b", {16'd0, bus.DOBH, bus.DOBL}, {16'd0, exp_rd(bus.AddrB)});
        chk("port_c", {16'd0, bus.DOCH, bus.DOCL}, {16'd0, exp_rd(bus.AddrC)});
        @(posedge clk);
        step();
        #1;
    endtask

    task automatic idle();
        bus.CEN = 1'b1;
        bus.WEH = 1'b0;
        bus.WEL = 1'b0;
        bus.EXX = 1'b0;
    endtask

    task automatic count_sweep(input int start);
        n = start;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        idle();
        bus.AddrA = 3'd0;
        bus.AddrB = 3'd0;
        bus.AddrC = 3'd0;
        bus.DIH = 8'h00;
        bus.DIL = 8'h00;
        @(posedge clk);
        step();
        #1;
        chk("reset_busy", {31'd0, bus.busy}, 32'd1);
        chk("reset_alt", {31'd0, bus.alt_sel}, 32'd0);
        tick();

        reset = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin
            if (n == 5) begin
                bus.AddrA = REG_DE;
                bus.DIH = 8'h11;
                bus.DIL = 8'h22;
                bus.WEH = 1'b1;
                bus.WEL = 1'b1;
            end
            tick();
            idle();
            n++;
        end
        chk("sweep_len", n, 16);
        bus.AddrB = REG_DE;
        #1;
        chk("discarded_write", {16'd0, bus.DOBH, bus.DOBL}, 32'h0000);
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        bus.CEN = 1'b0;
        repeat (10) begin
            tick();
            chk("stall_busy", {31'd0, bus.busy}, 32'd1);
        end
        bus.CEN = 1'b1;
        count_sweep(4);
        chk("stall_len", n, 16);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_sweep(0);
        chk("restart_len", n, 16);

        tv[0]  = '{REG_HL, REG_BC, 16'hABCD, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        tv[1]  = '{REG_HL, REG_HL, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hABCD, 1'b0};
        tv[2]  = '{REG_HL, REG_IX, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
        tv[3]  = '{REG_BC, REG_HL, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1};
        tv[4]  = '{REG_BC, REG_HL, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1};
        tv[5]  = '{REG_BC, REG_HL, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hABCD, 1'b0};
        tv[6]  = '{REG_IX, REG_BC, 16'h5566, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        tv[7]  = '{REG_BC, REG_IX, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h5566, 1'b0};
        tv[8]  = '{REG_BC, REG_IX, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h5566, 1'b1};
        tv[9]  = '{REG_BC, REG_HL, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1};
        tv[10] = '{REG_BC, REG_BC, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1};
        tv[11] = '{REG_BC, REG_DE, 16'h0077, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0};
        tv[12] = '{REG_IY, REG_BC, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
        tv[13] = '{REG_IY, REG_BC, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1};
        tv[14] = '{REG_IY, REG_BC, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0077, 1'b0};
        for (int i = 0; i < 15; i++) begin
            bus.AddrA = tv[i].a;
            bus.AddrB = tv[i].b;
            bus.AddrC = tv[i].a;
            {bus.DIH, bus.DIL} = tv[i].di;
            bus.WEH = tv[i].weh;
            bus.WEL = tv[i].wel;
            bus.EXX = tv[i].exx;
            #1;
            chk($sformatf("vec%0d_dob", i), {16'd0, bus.DOBH, bus.DOBL}, {16'd0, tv[i].exp_b});
            chk($sformatf("vec%0d_alt", i), {31'd0, bus.alt_sel}, {31'd0, tv[i].exp_alt});
            tick();
        end

        idle();
        bus.AddrA = REG_DE;
        bus.AddrB = REG_DE;
        bus.DIH = 8'h9A;
        bus.WEH = 1'b1;
        #1;
`ifdef TV80_REGFILE_BYPASS_EN
        chk("bypass_same_cycle", {24'd0, bus.DOBH}, 32'h9A);
`else
        chk("no_bypass_same_cycle", {24'd0, bus.DOBH}, 32'h00);
`endif
        tick();
        idle();
        #1;
        chk("write_next_cycle", {24'd0, bus.DOBH}, 32'h9A);

        repeat (400) begin
            reset = $urandom_range(0, 199) == 0;
            bus.CEN = ($urandom % 4) != 0;
            bus.AddrA = 3'($urandom);
            bus.AddrB = 3'($urandom);
            bus.AddrC = 3'($urandom);
            bus.DIH = 8'($urandom);
            bus.DIL = 8'($urandom);
            bus.WEH = 1'($urandom);
            bus.WEL = 1'($urandom);
            bus.EXX = ($urandom % 4) == 0;
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
